// File: rtl/vga_fb_wr_sched_pkg.sv
// Shared types and default widths for the VGA frame-buffer write path.
// Pixel codes and scheduler states are defined here.
package vga_pkg;

  localparam int ADDR_W  = 11;
  localparam int COLOR_W = 2;

  typedef enum logic [COLOR_W-1:0] {BLACK, WHITE, BLUE, GREEN} color_e;

  typedef enum logic [0:0] {ARB, CLEAR} sched_state_e;

endpackage

// File: rtl/vga_fb_wr_sched_if.sv
// Bundle between drawing agents, the write-port scheduler and the buffer write port.
// master = requester/controller side, slave = the scheduler.
interface vga_fb_wr_sched_if #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = vga_pkg::ADDR_W,
  parameter int COLOR_W = vga_pkg::COLOR_W
);

  logic                    wr_allow_i;
  logic [NREQ-1:0]         req_valid_i;
  logic [NREQ-1:0]         req_ready_o;
  logic [NREQ*ADDR_W-1:0]  req_x_i;
  logic [NREQ*ADDR_W-1:0]  req_y_i;
  logic [NREQ*COLOR_W-1:0] req_color_i;
  logic                    clear_req_i;
  logic [COLOR_W-1:0]      clear_color_i;
  logic                    clear_busy_o;
  logic                    clear_done_o;
  logic                    we_o;
  logic [ADDR_W-1:0]       addr_x_o;
  logic [ADDR_W-1:0]       addr_y_o;
  logic [COLOR_W-1:0]      color_o;
  logic [15:0]             drop_cnt_o;

  modport master (
    output wr_allow_i, req_valid_i, req_x_i, req_y_i, req_color_i,
           clear_req_i, clear_color_i,
    input  req_ready_o, clear_busy_o, clear_done_o, we_o,
           addr_x_o, addr_y_o, color_o, drop_cnt_o
  );

  modport slave (
    input  wr_allow_i, req_valid_i, req_x_i, req_y_i, req_color_i,
           clear_req_i, clear_color_i,
    output req_ready_o, clear_busy_o, clear_done_o, we_o,
           addr_x_o, addr_y_o, color_o, drop_cnt_o
  );

endinterface

// File: rtl/vga_fb_wr_sched_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index.
// The pointer only moves when the caller reports that the grant was used.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic [N-1:0]     req_i,
  input  logic             advance_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W-1:0] ptr_q;

  // Walk from farthest to nearest so the nearest requester after ptr_q wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = ptr_q;
    for (int k = N; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr_q) + k) % N;
      if (req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      ptr_q <= IDX_W'(N - 1);
    end else if (advance_i) begin
      ptr_q <= grant_idx_o;
    end
  end

endmodule

// File: rtl/vga_fb_wr_sched.sv
// Shares the frame buffer's single write port between NREQ pixel writers and
// a full-screen clear sweep that has priority over all of them.
module vga_fb_wr_sched #(
  parameter int NREQ    = 2,
  parameter int HD      = 1280,
  parameter int VD      = 1024,
  parameter int ADDR_W  = vga_pkg::ADDR_W,
  parameter int COLOR_W = vga_pkg::COLOR_W
) (
  input logic               clk,
  input logic               arstn,
  vga_fb_wr_sched_if.slave  bus
);

  import vga_pkg::*;

  localparam int          IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [0:0]  ST_ARB   = ARB;
  localparam logic [0:0]  ST_CLEAR = CLEAR;
  localparam logic [31:0] HD_U     = HD;
  localparam logic [31:0] VD_U     = VD;
  localparam logic [31:0] HD_LAST  = HD - 1;
  localparam logic [31:0] VD_LAST  = VD - 1;

  logic [0:0]         state_q, state_d;
  logic [ADDR_W-1:0]  sweep_x_q, sweep_x_d;
  logic [ADDR_W-1:0]  sweep_y_q, sweep_y_d;
  logic [COLOR_W-1:0] clr_color_q, clr_color_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  x_q, x_d;
  logic [ADDR_W-1:0]  y_q, y_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               done_q, done_d;
  logic [15:0]        drop_q, drop_d;

  logic               arb_en;
  logic [NREQ-1:0]    arb_req;
  logic [NREQ-1:0]    grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               xfer;
  logic [ADDR_W-1:0]  req_x     [NREQ];
  logic [ADDR_W-1:0]  req_y     [NREQ];
  logic [COLOR_W-1:0] req_color [NREQ];
  logic [ADDR_W-1:0]  sel_x, sel_y;
  logic [COLOR_W-1:0] sel_color;
  logic               in_range;
  logic               sweep_last;
  logic               sweep_eol;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_x[gi]     = bus.req_x_i[gi*ADDR_W +: ADDR_W];
    assign req_y[gi]     = bus.req_y_i[gi*ADDR_W +: ADDR_W];
    assign req_color[gi] = bus.req_color_i[gi*COLOR_W +: COLOR_W];
  end

  // A pending clear request blocks grants so the clear starts without a racing write.
  assign arb_en  = (state_q == ST_ARB) & bus.wr_allow_i & ~bus.clear_req_i;
  assign arb_req = bus.req_valid_i & {NREQ{arb_en}};
  assign xfer    = |grant;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk         (clk),
    .arstn       (arstn),
    .req_i       (arb_req),
    .advance_i   (xfer),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign sel_x      = req_x[grant_idx];
  assign sel_y      = req_y[grant_idx];
  assign sel_color  = req_color[grant_idx];
  assign in_range   = (32'(sel_x) < HD_U) && (32'(sel_y) < VD_U);
  assign sweep_eol  = (32'(sweep_x_q) == HD_LAST);
  assign sweep_last = sweep_eol && (32'(sweep_y_q) == VD_LAST);

  always_comb begin
    state_d     = state_q;
    sweep_x_d   = sweep_x_q;
    sweep_y_d   = sweep_y_q;
    clr_color_d = clr_color_q;
    we_d        = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    color_d     = color_q;
    done_d      = 1'b0;
    drop_d      = drop_q;
    case (state_q)
      ST_ARB: begin
        if (bus.clear_req_i) begin
          state_d     = ST_CLEAR;
          clr_color_d = bus.clear_color_i;
          sweep_x_d   = '0;
          sweep_y_d   = '0;
        end else if (xfer) begin
          // Out-of-range writes are consumed but never reach the buffer.
          if (in_range) begin
            we_d    = 1'b1;
            x_d     = sel_x;
            y_d     = sel_y;
            color_d = sel_color;
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
      end
      default: begin
        if (bus.wr_allow_i) begin
          we_d    = 1'b1;
          x_d     = sweep_x_q;
          y_d     = sweep_y_q;
          color_d = clr_color_q;
          if (sweep_last) begin
            state_d = ST_ARB;
            done_d  = 1'b1;
          end else if (sweep_eol) begin
            sweep_x_d = '0;
            sweep_y_d = sweep_y_q + ADDR_W'(1);
          end else begin
            sweep_x_d = sweep_x_q + ADDR_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= ST_ARB;
      sweep_x_q   <= '0;
      sweep_y_q   <= '0;
      clr_color_q <= '0;
      we_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      color_q     <= '0;
      done_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      sweep_x_q   <= sweep_x_d;
      sweep_y_q   <= sweep_y_d;
      clr_color_q <= clr_color_d;
      we_q        <= we_d;
      x_q         <= x_d;
      y_q         <= y_d;
      color_q     <= color_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.req_ready_o  = grant;
  assign bus.clear_busy_o = (state_q == ST_CLEAR);
  assign bus.clear_done_o = done_q;
  assign bus.we_o         = we_q;
  assign bus.addr_x_o     = x_q;
  assign bus.addr_y_o     = y_q;
  assign bus.color_o      = color_q;
  assign bus.drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_vga_fb_wr_sched.sv
// Cycle-by-cycle comparison of the write scheduler against a pixel-level model
// (grant search, linear sweep index, saturating drop count) under directed and random stimulus.
module tb_vga_fb_wr_sched;

  import vga_pkg::*;

  localparam int NREQ = 2;
  localparam int HD   = 4;
  localparam int VD   = 3;
  localparam int AW   = 11;
  localparam int CW   = 2;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  vga_fb_wr_sched_if #(.NREQ(NREQ), .ADDR_W(AW), .COLOR_W(CW)) bus ();

  vga_fb_wr_sched #(
    .NREQ(NREQ), .HD(HD), .VD(VD), .ADDR_W(AW), .COLOR_W(CW)
  ) dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stimulus for the next cycle
  logic            s_allow;
  logic [NREQ-1:0] s_valid;
  int              s_x   [NREQ];
  int              s_y   [NREQ];
  logic [CW-1:0]   s_col [NREQ];
  logic            s_clr;
  logic [CW-1:0]   s_ccol;

  // Reference model
  int            m_ptr;
  bit            m_clear;
  int            m_pix;
  int            m_drop;
  logic [CW-1:0] m_ccol;
  logic          e_we, e_busy, e_done;
  int            e_x, e_y;
  logic [CW-1:0] e_col;

  task automatic model_reset();
    m_ptr = NREQ - 1; m_clear = 0; m_pix = 0; m_drop = 0; m_ccol = '0;
    e_we = 0; e_x = 0; e_y = 0; e_col = '0; e_busy = 0; e_done = 0;
  endtask

  task automatic stim_idle();
    s_allow = 1'b0; s_valid = '0; s_clr = 1'b0; s_ccol = '0;
    for (int i = 0; i < NREQ; i++) begin s_x[i] = 0; s_y[i] = 0; s_col[i] = '0; end
  endtask

  task automatic apply_stim();
    logic [NREQ*AW-1:0] px, py;
    logic [NREQ*CW-1:0] pc;
    for (int i = 0; i < NREQ; i++) begin
      px[i*AW +: AW] = AW'(s_x[i]);
      py[i*AW +: AW] = AW'(s_y[i]);
      pc[i*CW +: CW] = s_col[i];
    end
    bus.wr_allow_i    = s_allow;
    bus.req_valid_i   = s_valid;
    bus.req_x_i       = px;
    bus.req_y_i       = py;
    bus.req_color_i   = pc;
    bus.clear_req_i   = s_clr;
    bus.clear_color_i = s_ccol;
  endtask

  task automatic check_outputs();
    check_val("we", 32'(bus.we_o), 32'(e_we));
    check_val("addr_x", 32'(bus.addr_x_o), 32'(e_x));
    check_val("addr_y", 32'(bus.addr_y_o), 32'(e_y));
    check_val("color", 32'(bus.color_o), 32'(e_col));
    check_val("busy", 32'(bus.clear_busy_o), 32'(e_busy));
    check_val("done", 32'(bus.clear_done_o), 32'(e_done));
    check_val("drop_cnt", 32'(bus.drop_cnt_o), 32'(m_drop));
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic do_cycle();
    logic [NREQ-1:0] e_rdy;
    int g;
    apply_stim();
    #1;
    e_rdy = '0;
    g = -1;
    if (!m_clear && s_allow && !s_clr) begin
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (g < 0 && s_valid[i]) g = i;
      end
    end
    if (g >= 0) e_rdy[g] = 1'b1;
    check_val("ready", 32'(bus.req_ready_o), 32'(e_rdy));
    e_we = 0;
    e_done = 0;
    if (!m_clear) begin
      if (s_clr) begin
        m_clear = 1; m_pix = 0; m_ccol = s_ccol;
      end else if (g >= 0) begin
        m_ptr = g;
        if (s_x[g] < HD && s_y[g] < VD) begin
          e_we = 1; e_x = s_x[g]; e_y = s_y[g]; e_col = s_col[g];
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
    end else if (s_allow) begin
      e_we = 1; e_x = m_pix % HD; e_y = m_pix / HD; e_col = m_ccol;
      m_pix++;
      if (m_pix == HD * VD) begin m_clear = 0; e_done = 1; end
    end
    e_busy = m_clear;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    stim_idle();
    apply_stim();
    arstn = 1'b0;
    model_reset();
    #1;
    check_outputs();
    check_val("ready_in_reset", 32'(bus.req_ready_o), 32'd0);
    #2;
    arstn = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    stim_idle();
    apply_stim();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // 1: single write from r0
    s_allow = 1; s_valid = 2'b01; s_x[0] = 1; s_y[0] = 2; s_col[0] = WHITE;
    do_cycle();
    stim_idle(); do_cycle();

    // 2: both valid for 4 cycles, alternating grants
    for (int c = 0; c < 4; c++) begin
      s_allow = 1; s_valid = 2'b11;
      s_x[0] = c; s_y[0] = 0; s_col[0] = BLUE;
      s_x[1] = 3 - c; s_y[1] = 2; s_col[1] = GREEN;
      do_cycle();
    end
    stim_idle(); do_cycle();

    // 3: r1 only, wr_allow 1,0,1
    for (int c = 0; c < 3; c++) begin
      s_allow = (c != 1); s_valid = 2'b10; s_x[1] = c; s_y[1] = 1; s_col[1] = WHITE;
      do_cycle();
    end
    stim_idle(); do_cycle();

    // 4: clear with BLUE while r0 stays valid
    s_allow = 1; s_clr = 1; s_ccol = BLUE; s_valid = 2'b01;
    s_x[0] = 2; s_y[0] = 1; s_col[0] = GREEN;
    do_cycle();
    s_clr = 0;
    for (int c = 0; c < 15; c++) do_cycle();
    stim_idle(); do_cycle();

    // 5: out-of-range writes, then drive the drop counter into saturation
    s_allow = 1; s_valid = 2'b01; s_x[0] = 4; s_y[0] = 0; s_col[0] = WHITE;
    do_cycle();
    s_valid = 2'b11; s_x[1] = 0; s_y[1] = 3;
    for (int c = 0; c < 65540; c++) do_cycle();
    stim_idle(); do_cycle();

    // 6: reset mid-sweep, then a fresh clear from the origin
    s_allow = 1; s_clr = 1; s_ccol = GREEN;
    do_cycle();
    s_clr = 0;
    for (int c = 0; c < 5; c++) do_cycle();
    do_reset();
    stim_idle(); do_cycle();
    s_allow = 1; s_clr = 1; s_ccol = WHITE;
    do_cycle();
    s_clr = 0;
    for (int c = 0; c < 14; c++) do_cycle();

    // Random traffic, including clear requests arriving in either state
    for (int c = 0; c < 1000; c++) begin
      s_allow = ($urandom_range(0, 3) != 0);
      s_valid = NREQ'($urandom_range(0, 3));
      for (int i = 0; i < NREQ; i++) begin
        s_x[i]   = $urandom_range(0, 5);
        s_y[i]   = $urandom_range(0, 4);
        s_col[i] = CW'($urandom_range(0, 3));
      end
      s_clr  = ($urandom_range(0, 39) == 0);
      s_ccol = CW'($urandom_range(0, 3));
      do_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
